// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
//
// Top-level sequencer for one image frame passing through the datapath
// (input FIFO -> model -> post-process -> output BRAM). The block walks
// through IDLE -> RUN -> DONE -> FLUSH -> IDLE. It has a watchdog that
// aborts a frame which stays in RUN for too long. Each pass through FLUSH
// ends with a fixed-length reset of the datapath.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of cycles spent in RUN before the
//                    watchdog forces a FLUSH
//   RESET_CYCLES   : number of cycles soft_rst_n is held low in FLUSH
//   COUNT_WIDTH    : width of frame_count
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   first_pixel in   pulse, first pixel of a frame accepted
//   model_done  in   level, frame result complete in output BRAM
//   result_ack  in   pulse, host finished reading results
//   abort       in   pulse, host abort request
//   soft_rst_n  out  active-low datapath reset, low only in FLUSH
//   busy        out  high in RUN
//   irq         out  level interrupt, high in DONE
//   state       out  IDLE=0, RUN=1, DONE=2, FLUSH=3
//   frame_count out  completed frames, wraps modulo 2^COUNT_WIDTH
//   timeout     out  sticky, last frame was aborted by the watchdog
// ---------------------------------------------------------------------------
module frame_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 16777216,
  parameter int unsigned RESET_CYCLES   = 15,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   first_pixel,
  input  logic                   model_done,
  input  logic                   result_ack,
  input  logic                   abort,
  output logic                   soft_rst_n,
  output logic                   busy,
  output logic                   irq,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic                   timeout
);

  // The counters only have to reach N-1, so $clog2(N) bits are enough.
  // At least one bit is kept so that a parameter value of 1 still
  // elaborates.
  localparam int unsigned CYC_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned FLUSH_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;

  // Qualified events in the current state. Each event already includes
  // the exit priority of its state.
  logic start_run;     // IDLE -> RUN
  logic frame_done;    // RUN  -> DONE, counts a frame
  logic wd_expire;     // RUN  -> FLUSH by the watchdog
  logic enter_flush;   // any  -> FLUSH

  assign state = state_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: each signal gets a default at the top of the block. Without the
  // default, a path that skips the assignment would infer a latch.
  always_comb begin
    state_d    = state_q;
    start_run  = 1'b0;
    frame_done = 1'b0;
    wd_expire  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Abort wins over first_pixel. It flushes a datapath that may hold
        // leftovers.
        if (abort) begin
          state_d = FLUSH;
        end else if (first_pixel) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end

      RUN: begin
        // A result that arrives on the same cycle as watchdog expiry
        // still counts as a completed frame.
        if (abort) begin
          state_d = FLUSH;
        end else if (model_done) begin
          state_d    = DONE;
          frame_done = 1'b1;
        end else if (cyc_cnt == CYC_LAST) begin
          state_d   = FLUSH;
          wd_expire = 1'b1;
        end
      end

      DONE: begin
        // model_done stays high while the host reads, so it is not looked
        // at here.
        if (result_ack || abort) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        // No input can shorten or restart the datapath reset.
        if (flush_cnt == FLUSH_LAST) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign enter_flush = (state_d == FLUSH) && (state_q != FLUSH);

  // -------------------------------------------------------------------------
  // State, counters and registered outputs
  // -------------------------------------------------------------------------
  // The outputs are decoded from state_d. Because of that, busy, irq and
  // soft_rst_n change on the same edge as state and always agree with it.
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples the values from before the edge, whatever order
  // the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      irq         <= 1'b0;
      soft_rst_n  <= 1'b1;
      cyc_cnt     <= '0;
      flush_cnt   <= '0;
      frame_count <= '0;
      timeout     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d == RUN);
      irq        <= (state_d == DONE);
      soft_rst_n <= (state_d != FLUSH);

      // Watchdog: cleared when a frame starts, then counts each RUN cycle.
      // It saturates at the last value so it can never wrap.
      if (start_run) begin
        cyc_cnt <= '0;
      end else if ((state_q == RUN) && (cyc_cnt != CYC_LAST)) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end

      // Flush length counter: cleared on entry, then counts each FLUSH cycle.
      if (enter_flush) begin
        flush_cnt <= '0;
      end else if ((state_q == FLUSH) && (flush_cnt != FLUSH_LAST)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end

      // Only a completed frame moves the counter. It wraps on overflow.
      if (frame_done) begin
        frame_count <= frame_count + 1'b1;
      end

      // timeout records the result of the last frame. It stays set until
      // the next frame starts.
      if (start_run) begin
        timeout <= 1'b0;
      end else if (wd_expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
//
// Directed bench for frame_scheduler. Two instances share one set of
// inputs:
//   dut_a : default parameters (long watchdog, 16-bit frame counter)
//   dut_b : TIMEOUT_CYCLES=64, COUNT_WIDTH=2 for the watchdog, same-cycle
//           and wrap scenarios
// Inputs change 1 time unit after the rising edge. Outputs are sampled at
// that same point, so they show the state written by the edge just past.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       first_pixel = 1'b0;
  logic       model_done = 1'b0;
  logic       result_ack = 1'b0;
  logic       abort = 1'b0;

  logic        soft_a, busy_a, irq_a, timeout_a;
  logic [1:0]  state_a;
  logic [15:0] fc_a;

  logic        soft_b, busy_b, irq_b, timeout_b;
  logic [1:0]  state_b;
  logic [1:0]  fc_b;

  int tests  = 0;
  int failed = 0;
  int n;

  always #5 clk = ~clk;

  frame_scheduler dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .first_pixel (first_pixel),
    .model_done  (model_done),
    .result_ack  (result_ack),
    .abort       (abort),
    .soft_rst_n  (soft_a),
    .busy        (busy_a),
    .irq         (irq_a),
    .state       (state_a),
    .frame_count (fc_a),
    .timeout     (timeout_a)
  );

  frame_scheduler #(
    .TIMEOUT_CYCLES (64),
    .RESET_CYCLES   (15),
    .COUNT_WIDTH    (2)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .first_pixel (first_pixel),
    .model_done  (model_done),
    .result_ack  (result_ack),
    .abort       (abort),
    .soft_rst_n  (soft_b),
    .busy        (busy_b),
    .irq         (irq_b),
    .state       (state_b),
    .frame_count (fc_b),
    .timeout     (timeout_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits a bounded number of cycles for one instance (0=a, 1=b) to reach
  // IDLE. Running out of cycles shows up as a failed check.
  task automatic wait_idle(input int which, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (((which == 0) ? state_a : state_b) == 2'd0) break;
      tick();
    end
    check(tag, 32'((which == 0) ? state_a : state_b), 32'd0);
  endtask

  // Counts the cycles dut_a holds soft_rst_n low until it reaches IDLE.
  task automatic count_flush(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (soft_a == 1'b0) cnt++;
      if (state_a == 2'd0) break;
      tick();
    end
  endtask

  initial begin
    // ---------------- reset values ----------------
    reset_all();
    check("rst_state",   32'(state_a), 32'd0);
    check("rst_soft",    32'(soft_a),  32'd1);
    check("rst_busy",    32'(busy_a),  32'd0);
    check("rst_irq",     32'(irq_a),   32'd0);
    check("rst_count",   32'(fc_a),    32'd0);
    check("rst_timeout", 32'(timeout_a), 32'd0);

    // ---------------- normal frame (dut_a) ----------------
    first_pixel = 1'b1;
    tick();
    first_pixel = 1'b0;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy_a) n++;
      if (i == 999) model_done = 1'b1;
      tick();
    end
    check("norm_busy_cycles", 32'(n), 32'd1000);
    check("norm_busy_off",    32'(busy_a), 32'd0);
    check("norm_state_done",  32'(state_a), 32'd2);
    check("norm_count",       32'(fc_a), 32'd1);
    // model_done stays high in DONE and must not count again
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (irq_a) n++;
      tick();
    end
    check("norm_irq_cycles",  32'(n), 32'd10);
    check("norm_still_done",  32'(state_a), 32'd2);
    check("norm_count_hold",  32'(fc_a), 32'd1);
    model_done = 1'b0;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("norm_flush_state", 32'(state_a), 32'd3);
    check("norm_irq_clear",   32'(irq_a), 32'd0);
    count_flush(n);
    check("norm_flush_len",   32'(n), 32'd15);
    check("norm_back_idle",   32'(state_a), 32'd0);
    check("norm_soft_high",   32'(soft_a), 32'd1);

    // ---------------- watchdog (dut_b, 64 cycles) ----------------
    reset_all();
    first_pixel = 1'b1;
    tick();
    first_pixel = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (state_b != 2'd1) break;
      n++;
      tick();
    end
    check("wd_run_cycles", 32'(n), 32'd64);
    check("wd_state",      32'(state_b), 32'd3);
    check("wd_timeout",    32'(timeout_b), 32'd1);
    check("wd_count",      32'(fc_b), 32'd0);
    wait_idle(1, "wd_idle");
    check("wd_sticky",     32'(timeout_b), 32'd1);
    first_pixel = 1'b1;
    tick();
    first_pixel = 1'b0;
    check("wd_cleared",    32'(timeout_b), 32'd0);
    check("wd_rerun",      32'(state_b), 32'd1);

    // ---------------- model_done at watchdog expiry ----------------
    reset_all();
    first_pixel = 1'b1;
    tick();
    first_pixel = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) model_done = 1'b1;
      tick();
    end
    model_done = 1'b0;
    check("tie_state",   32'(state_b), 32'd2);
    check("tie_timeout", 32'(timeout_b), 32'd0);
    check("tie_count",   32'(fc_b), 32'd1);

    // ---------------- abort together with model_done in RUN ----------------
    reset_all();
    first_pixel = 1'b1;
    tick();
    first_pixel = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    model_done = 1'b1;
    tick();
    abort = 1'b0;
    model_done = 1'b0;
    check("abort_state_a", 32'(state_a), 32'd3);
    check("abort_count_a", 32'(fc_a), 32'd0);
    check("abort_state_b", 32'(state_b), 32'd3);
    check("abort_count_b", 32'(fc_b), 32'd0);

    // ---------------- abort priority in IDLE, ignored inputs in FLUSH ----------------
    reset_all();
    abort = 1'b1;
    first_pixel = 1'b1;
    tick();
    abort = 1'b0;
    first_pixel = 1'b0;
    check("idle_abort_prio", 32'(state_a), 32'd3);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (soft_a == 1'b0) n++;
      if (state_a == 2'd0) break;
      first_pixel = (i == 2);
      result_ack  = (i == 5);
      abort       = (i == 8);
      model_done  = (i == 11);
      tick();
    end
    first_pixel = 1'b0;
    result_ack  = 1'b0;
    abort       = 1'b0;
    model_done  = 1'b0;
    check("ign_flush_len", 32'(n), 32'd15);
    check("ign_idle",      32'(state_a), 32'd0);
    tick();
    check("ign_not_run",   32'(state_a), 32'd0);

    // ---------------- frame_count wrap (dut_b has 2 bits) ----------------
    reset_all();
    for (int f = 0; f < 5; f++) begin
      first_pixel = 1'b1;
      tick();
      first_pixel = 1'b0;
      repeat (3) tick();
      model_done = 1'b1;
      tick();
      model_done = 1'b0;
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      wait_idle(0, "wrap_idle_a");
      wait_idle(1, "wrap_idle_b");
    end
    check("wrap_count_b", 32'(fc_b), 32'd1);
    check("wrap_count_a", 32'(fc_a), 32'd5);

    // ---------------- asynchronous reset mid-RUN ----------------
    first_pixel = 1'b1;
    tick();
    first_pixel = 1'b0;
    repeat (5) tick();
    check("ar_busy_before", 32'(busy_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;  // still 6 time units ahead of the next rising edge
    check("ar_state",   32'(state_a), 32'd0);
    check("ar_busy",    32'(busy_a), 32'd0);
    check("ar_irq",     32'(irq_a), 32'd0);
    check("ar_soft",    32'(soft_a), 32'd1);
    check("ar_count_a", 32'(fc_a), 32'd0);
    check("ar_count_b", 32'(fc_b), 32'd0);
    check("ar_state_b", 32'(state_b), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("ar_wait_idle",  32'(state_a), 32'd0);
    check("ar_count_hold", 32'(fc_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 16777216: maximum cycles allowed in RUN before forced abort.
- REQ-002: Parameter RESET_CYCLES, default 15: number of cycles soft_rst_n is held low in FLUSH.
- REQ-003: Parameter COUNT_WIDTH, default 16: width of frame_count.
- REQ-004: clk  input  1  single clock; all logic rising-edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: first_pixel  input  1  one-cycle pulse; first input pixel of a frame accepted by the input FIFO writer.
- REQ-007: model_done  input  1  level; post-process output valid (frame result complete in output BRAM).
- REQ-008: result_ack  input  1  one-cycle pulse; host finished reading results.
- REQ-009: abort  input  1  one-cycle pulse; host abort request.
- REQ-010: soft_rst_n  output  1  active-low reset to the datapath (FIFOs, model, post-process).
- REQ-011: busy  output  1  high in RUN only.
- REQ-012: irq  output  1  level interrupt, high in DONE only.
- REQ-013: state  output  2  encoded state: IDLE=0, RUN=1, DONE=2, FLUSH=3.
- REQ-014: frame_count  output  COUNT_WIDTH  number of frames completed.
- REQ-015: timeout  output  1  sticky flag, last frame was aborted by watchdog.

Function
- REQ-016: All outputs SHALL be registered; a state transition SHALL take effect on the clock edge at which the causing input is sampled, and outputs SHALL reflect the new state in the following cycle.
- REQ-017: IDLE: first_pixel=1 -> RUN, cycle counter cleared to 0, timeout cleared to 0; abort=1 -> FLUSH; abort has priority over first_pixel.
- REQ-018: RUN: cycle counter SHALL increment by 1 each cycle, saturating at TIMEOUT_CYCLES-1.
- REQ-019: RUN exit priority, highest first: abort -> FLUSH; model_done -> DONE with frame_count incremented; cycle counter == TIMEOUT_CYCLES-1 -> FLUSH with timeout set to 1.
- REQ-020: model_done and watchdog expiry in the same cycle SHALL result in DONE, with timeout remaining 0.
- REQ-021: frame_count SHALL wrap modulo 2^COUNT_WIDTH; frame_count SHALL be affected only by REQ-019 and rst_n.
- REQ-022: DONE: result_ack=1 or abort=1 -> FLUSH; model_done SHALL be ignored.
- REQ-023: FLUSH: soft_rst_n SHALL be 0 for exactly RESET_CYCLES consecutive cycles starting the cycle after entry, then the block SHALL return to IDLE, with soft_rst_n=1 from the IDLE cycle onward.
- REQ-024: In FLUSH, abort, result_ack, first_pixel and model_done SHALL be ignored, and the flush count SHALL NOT restart.
- REQ-025: first_pixel in RUN, DONE or FLUSH SHALL be ignored; result_ack outside DONE SHALL be ignored.
- REQ-026: Outputs SHALL be decoded from state: busy=(state==RUN), irq=(state==DONE), soft_rst_n=~(state==FLUSH).
- REQ-027: The cycle counter and flush counter SHALL be sized from $clog2 of their parameters, with no truncation at default values.

Reset
- REQ-028: rst_n=0 SHALL immediately and asynchronously force state=IDLE, soft_rst_n=1, busy=0, irq=0, frame_count=0, timeout=0, and both internal counters to 0.
- REQ-029: rst_n asserted mid-RUN or mid-FLUSH SHALL abandon the operation with no frame_count update; after release the block SHALL wait in IDLE.

Verification
- REQ-030: Normal frame: first_pixel pulse, model_done after 1000 cycles, result_ack after 10 more cycles -> busy high for 1000 cycles, irq high until ack, frame_count=1, soft_rst_n low for exactly 15 cycles, back in IDLE (state=0).
- REQ-031: Watchdog (TIMEOUT_CYCLES=64): first_pixel, no model_done -> FLUSH entered after 64 RUN cycles, timeout=1, frame_count unchanged; the next first_pixel clears timeout.
- REQ-032: Same-cycle events: model_done at watchdog expiry -> DONE, timeout=0; abort with model_done in RUN -> FLUSH, frame_count unchanged.
- REQ-033: Ignored inputs: first_pixel and result_ack pulses during FLUSH -> flush length still 15 cycles, state returns to IDLE, not RUN.
- REQ-034: Wrap and reset: COUNT_WIDTH=2 with 5 completed frames -> frame_count=1; rst_n pulsed low mid-RUN -> all outputs at reset values asynchronously, before the next clock edge.
